digit_entry: RTL and testbench

DIGIT_ENTRY -- requirements
Module: digit_entry

---
 rtl/digit_entry_if.sv | 25 ++
 rtl/digit_entry.sv | 113 +++++++++++
 tb/tb_digit_entry.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/digit_entry_if.sv
// Keypad-side and timer-side signals of the digit entry block, bundled.
// master drives keypad levels and observes the digits; slave is the entry logic.
interface digit_entry_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       enter;
  logic       cancel;
  logic       timer_running;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       load;
  logic [1:0] digit_count;
  logic       error;

  modport master (
    output key_code, key_valid, enter, cancel, timer_running,
    input  min_ones, sec_tens, sec_ones, load, digit_count, error
  );

  modport slave (
    input  key_code, key_valid, enter, cancel, timer_running,
    output min_ones, sec_tens, sec_ones, load, digit_count, error
  );
endinterface

// File: rtl/digit_entry.sv
// Keypad digit entry for a M:SS countdown timer: collects up to three BCD digits,
// validates them on Start and pulses load into the downstream counters.
module digit_entry (
  input  logic         clk,
  input  logic         clear_n,
  digit_entry_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD} state_t;

  state_t     state_reg, state_next;
  logic [3:0] min_reg, min_next;
  logic [3:0] tens_reg, tens_next;
  logic [3:0] ones_reg, ones_next;
  logic [1:0] count_reg, count_next;
  logic       error_reg, error_next;

  logic [2:0] level;
  logic [2:0] prev_reg;
  logic [2:0] event_hit;
  logic       key_ev, enter_ev, cancel_ev;
  logic       key_ok;

  assign level = {bus.cancel, bus.enter, bus.key_valid};

  // One edge detector per input; a level held through reset release still
  // reads as a fresh press because the history resets to 0.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) prev_reg[gi] <= 1'b0;
        else          prev_reg[gi] <= level[gi];
      end
      assign event_hit[gi] = level[gi] & ~prev_reg[gi];
    end
  endgenerate

  assign key_ev    = event_hit[0];
  assign enter_ev  = event_hit[1];
  assign cancel_ev = event_hit[2];
  assign key_ok    = (bus.key_code <= 4'd9);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_reg <= IDLE;
      min_reg   <= 4'd0;
      tens_reg  <= 4'd0;
      ones_reg  <= 4'd0;
      count_reg <= 2'd0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      min_reg   <= min_next;
      tens_reg  <= tens_next;
      ones_reg  <= ones_next;
      count_reg <= count_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    min_next   = min_reg;
    tens_next  = tens_reg;
    ones_next  = ones_reg;
    count_next = count_reg;
    error_next = 1'b0;

    if (cancel_ev) begin
      state_next = IDLE;
      min_next   = 4'd0;
      tens_next  = 4'd0;
      ones_next  = 4'd0;
      count_next = 2'd0;
    end else if (state_reg == LOAD) begin
      // The load cycle always falls back to IDLE; other presses are dropped.
      state_next = IDLE;
    end else if (bus.timer_running) begin
      state_next = state_reg;
    end else if (enter_ev) begin
      // Tens-of-seconds above 5 is not a valid time, so Start is refused.
      if (state_reg == ENTRY && tens_reg <= 4'd5) begin
        state_next = LOAD;
        count_next = 2'd0;
      end else begin
        error_next = 1'b1;
      end
    end else if (key_ev) begin
      if (!key_ok) begin
        error_next = 1'b1;
      end else if (state_reg == IDLE) begin
        state_next = ENTRY;
        min_next   = 4'd0;
        tens_next  = 4'd0;
        ones_next  = bus.key_code;
        count_next = 2'd1;
      end else begin
        min_next   = tens_reg;
        tens_next  = ones_reg;
        ones_next  = bus.key_code;
        count_next = (count_reg == 2'd3) ? 2'd3 : count_reg + 2'd1;
      end
    end
  end

  assign bus.min_ones    = min_reg;
  assign bus.sec_tens    = tens_reg;
  assign bus.sec_ones    = ones_reg;
  assign bus.digit_count = count_reg;
  assign bus.error       = error_reg;
  assign bus.load        = (state_reg == LOAD);

endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry: stimulus pushes the expected post-edge outputs
// into a scoreboard queue, a monitor pops one entry per clock and compares.
module tb_digit_entry;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  digit_entry_if bus ();

  digit_entry dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic [1:0] c;
    logic       l;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic void push(input string name, input logic [3:0] m, input logic [3:0] t,
                               input logic [3:0] o, input logic [1:0] c, input logic l,
                               input logic e);
    exp_t x;
    x.name = name; x.m = m; x.t = t; x.o = o; x.c = c; x.l = l; x.e = e;
    sb.push_back(x);
  endfunction

  // One cycle: drive levels after the falling edge, expect outputs after the next rise.
  task automatic step(input string name, input logic [3:0] code, input logic kv, input logic en,
                      input logic ca, input logic tr, input logic [3:0] m, input logic [3:0] t,
                      input logic [3:0] o, input logic [1:0] c, input logic l, input logic e);
    @(negedge clk);
    bus.key_code      = code;
    bus.key_valid     = kv;
    bus.enter         = en;
    bus.cancel        = ca;
    bus.timer_running = tr;
    push(name, m, t, o, c, l, e);
  endtask

  task automatic check_zero(input string name);
    total++;
    if (bus.min_ones !== 4'd0 || bus.sec_tens !== 4'd0 || bus.sec_ones !== 4'd0 ||
        bus.digit_count !== 2'd0 || bus.load !== 1'b0 || bus.error !== 1'b0) begin
      bad++;
      $display("FAIL %s: got %0d%0d%0d cnt=%0d load=%0b err=%0b, want all zero", name,
               bus.min_ones, bus.sec_tens, bus.sec_ones, bus.digit_count, bus.load, bus.error);
    end else begin
      $display("chk %s ok", name);
    end
  endtask

  // Monitor: compare every clock for which stimulus queued an expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        total++;
        if (bus.min_ones !== x.m || bus.sec_tens !== x.t || bus.sec_ones !== x.o ||
            bus.digit_count !== x.c || bus.load !== x.l || bus.error !== x.e) begin
          bad++;
          $display("FAIL %s: got %0d%0d%0d cnt=%0d load=%0b err=%0b, want %0d%0d%0d cnt=%0d load=%0b err=%0b",
                   x.name, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.digit_count, bus.load,
                   bus.error, x.m, x.t, x.o, x.c, x.l, x.e);
        end else begin
          $display("chk %s ok", x.name);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    bus.key_code = 4'd0;
    bus.key_valid = 1'b0;
    bus.enter = 1'b0;
    bus.cancel = 1'b0;
    bus.timer_running = 1'b0;
    clear_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    clear_n = 1'b1;

    // 1,3,0 then Start
    step("k1",     4'd1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd1, 2'd1, 0, 0);
    step("k1_rel", 4'd1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd1, 2'd1, 0, 0);
    step("k3",     4'd3, 1, 0, 0, 0, 4'd0, 4'd1, 4'd3, 2'd2, 0, 0);
    step("k3_rel", 4'd3, 0, 0, 0, 0, 4'd0, 4'd1, 4'd3, 2'd2, 0, 0);
    step("k0",     4'd0, 1, 0, 0, 0, 4'd1, 4'd3, 4'd0, 2'd3, 0, 0);
    step("k0_rel", 4'd0, 0, 0, 0, 0, 4'd1, 4'd3, 4'd0, 2'd3, 0, 0);
    step("ent130", 4'd0, 0, 1, 0, 0, 4'd1, 4'd3, 4'd0, 2'd0, 1, 0);
    step("post130",4'd0, 0, 0, 0, 0, 4'd1, 4'd3, 4'd0, 2'd0, 0, 0);
    step("hold130",4'd0, 0, 0, 0, 0, 4'd1, 4'd3, 4'd0, 2'd0, 0, 0);

    // 5,0 then Start; Start again from IDLE is refused
    step("k5",     4'd5, 1, 0, 0, 0, 4'd0, 4'd0, 4'd5, 2'd1, 0, 0);
    step("k5_rel", 4'd5, 0, 0, 0, 0, 4'd0, 4'd0, 4'd5, 2'd1, 0, 0);
    step("k0b",    4'd0, 1, 0, 0, 0, 4'd0, 4'd5, 4'd0, 2'd2, 0, 0);
    step("k0b_rel",4'd0, 0, 0, 0, 0, 4'd0, 4'd5, 4'd0, 2'd2, 0, 0);
    step("ent050", 4'd0, 0, 1, 0, 0, 4'd0, 4'd5, 4'd0, 2'd0, 1, 0);
    step("post050",4'd0, 0, 0, 0, 0, 4'd0, 4'd5, 4'd0, 2'd0, 0, 0);
    step("ent_idl",4'd0, 0, 1, 0, 0, 4'd0, 4'd5, 4'd0, 2'd0, 0, 1);
    step("ent_rel",4'd0, 0, 0, 0, 0, 4'd0, 4'd5, 4'd0, 2'd0, 0, 0);

    // 1,2,3,4,7,9 then Start with tens=7
    step("s1", 4'd1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd1, 2'd1, 0, 0);
    step("r1", 4'd1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd1, 2'd1, 0, 0);
    step("s2", 4'd2, 1, 0, 0, 0, 4'd0, 4'd1, 4'd2, 2'd2, 0, 0);
    step("r2", 4'd2, 0, 0, 0, 0, 4'd0, 4'd1, 4'd2, 2'd2, 0, 0);
    step("s3", 4'd3, 1, 0, 0, 0, 4'd1, 4'd2, 4'd3, 2'd3, 0, 0);
    step("r3", 4'd3, 0, 0, 0, 0, 4'd1, 4'd2, 4'd3, 2'd3, 0, 0);
    step("s4", 4'd4, 1, 0, 0, 0, 4'd2, 4'd3, 4'd4, 2'd3, 0, 0);
    step("r4", 4'd4, 0, 0, 0, 0, 4'd2, 4'd3, 4'd4, 2'd3, 0, 0);
    step("s7", 4'd7, 1, 0, 0, 0, 4'd3, 4'd4, 4'd7, 2'd3, 0, 0);
    step("r7", 4'd7, 0, 0, 0, 0, 4'd3, 4'd4, 4'd7, 2'd3, 0, 0);
    step("s9", 4'd9, 1, 0, 0, 0, 4'd4, 4'd7, 4'd9, 2'd3, 0, 0);
    step("r9", 4'd9, 0, 0, 0, 0, 4'd4, 4'd7, 4'd9, 2'd3, 0, 0);
    step("ent_t7", 4'd9, 0, 1, 0, 0, 4'd4, 4'd7, 4'd9, 2'd3, 0, 1);
    step("ent_t7r",4'd9, 0, 0, 0, 0, 4'd4, 4'd7, 4'd9, 2'd3, 0, 0);
    step("cxl_a",  4'd9, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0);
    step("cxl_ar", 4'd9, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0);

    // long holds produce one shift each; invalid code is refused
    step("h4", 4'd4, 1, 0, 0, 0, 4'd0, 4'd0, 4'd4, 2'd1, 0, 0);
    for (int i = 0; i < 19; i++)
      step("h4_held", 4'd4, 1, 0, 0, 0, 4'd0, 4'd0, 4'd4, 2'd1, 0, 0);
    step("h4_rel", 4'd4, 0, 0, 0, 0, 4'd0, 4'd0, 4'd4, 2'd1, 0, 0);
    step("h2", 4'd2, 1, 0, 0, 0, 4'd0, 4'd4, 4'd2, 2'd2, 0, 0);
    for (int i = 0; i < 19; i++)
      step("h2_held", 4'd2, 1, 0, 0, 0, 4'd0, 4'd4, 4'd2, 2'd2, 0, 0);
    step("h2_rel", 4'd2, 0, 0, 0, 0, 4'd0, 4'd4, 4'd2, 2'd2, 0, 0);
    step("k12",    4'd12, 1, 0, 0, 0, 4'd0, 4'd4, 4'd2, 2'd2, 0, 1);
    step("k12_rel",4'd12, 0, 0, 0, 0, 4'd0, 4'd4, 4'd2, 2'd2, 0, 0);

    // cancel beats a simultaneous Start
    step("cxl_b",  4'd0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0);
    step("cxl_br", 4'd0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0);
    step("c3",     4'd3, 1, 0, 0, 0, 4'd0, 4'd0, 4'd3, 2'd1, 0, 0);
    step("c3_rel", 4'd3, 0, 0, 0, 0, 4'd0, 4'd0, 4'd3, 2'd1, 0, 0);
    step("c5",     4'd5, 1, 0, 0, 0, 4'd0, 4'd3, 4'd5, 2'd2, 0, 0);
    step("c5_rel", 4'd5, 0, 0, 0, 0, 4'd0, 4'd3, 4'd5, 2'd2, 0, 0);
    step("cxl_ent",4'd5, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0);
    step("cxl_er", 4'd5, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0);
    step("ent_id2",4'd5, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 1);
    step("ent_id2r",4'd5,0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0);

    // timer running: key and Start ignored silently, cancel still works
    step("t1",     4'd1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd1, 2'd1, 0, 0);
    step("t1_rel", 4'd1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd1, 2'd1, 0, 0);
    step("tr_k8",  4'd8, 1, 0, 0, 1, 4'd0, 4'd0, 4'd1, 2'd1, 0, 0);
    step("tr_k8r", 4'd8, 0, 0, 0, 1, 4'd0, 4'd0, 4'd1, 2'd1, 0, 0);
    step("tr_ent", 4'd8, 0, 1, 0, 1, 4'd0, 4'd0, 4'd1, 2'd1, 0, 0);
    step("tr_entr",4'd8, 0, 0, 0, 1, 4'd0, 4'd0, 4'd1, 2'd1, 0, 0);
    step("tr_cxl", 4'd8, 0, 0, 1, 1, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0);
    step("tr_cxlr",4'd8, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0);

    // reset in the middle of the load cycle
    step("l2",     4'd2, 1, 0, 0, 0, 4'd0, 4'd0, 4'd2, 2'd1, 0, 0);
    step("l2_rel", 4'd2, 0, 0, 0, 0, 4'd0, 4'd0, 4'd2, 2'd1, 0, 0);
    step("l3",     4'd3, 1, 0, 0, 0, 4'd0, 4'd2, 4'd3, 2'd2, 0, 0);
    step("l3_rel", 4'd3, 0, 0, 0, 0, 4'd0, 4'd2, 4'd3, 2'd2, 0, 0);
    step("ent023", 4'd3, 0, 1, 0, 0, 4'd0, 4'd2, 4'd3, 2'd0, 1, 0);
    @(negedge clk);
    clear_n = 1'b0;
    #1;
    check_zero("rst_mid_load");
    bus.enter = 1'b0;
    bus.key_code = 4'd6;
    bus.key_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("rst_held");

    // a key held across release counts on the first clock
    @(negedge clk);
    clear_n = 1'b1;
    push("rel_k6", 4'd0, 4'd0, 4'd6, 2'd1, 1'b0, 1'b0);
    step("rel_k6h", 4'd6, 1, 0, 0, 0, 4'd0, 4'd0, 4'd6, 2'd1, 0, 0);
    step("rel_k6r", 4'd6, 0, 0, 0, 0, 4'd0, 4'd0, 4'd6, 2'd1, 0, 0);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 50) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
